// File: rtl/conv1_window_ctrl.sv
// Window controller for the binary 3x3 conv1 stage: buffers two raster lines and
// presents every complete 3x3 window of a frame with a valid/ready handshake.
module conv1_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] pixel_0,
  output logic [PIX_W-1:0] pixel_1,
  output logic [PIX_W-1:0] pixel_2,
  output logic [PIX_W-1:0] pixel_3,
  output logic [PIX_W-1:0] pixel_4,
  output logic [PIX_W-1:0] pixel_5,
  output logic [PIX_W-1:0] pixel_6,
  output logic [PIX_W-1:0] pixel_7,
  output logic [PIX_W-1:0] pixel_8,
  output logic             valid_out_buf,
  input  logic             win_ready,
  output logic [4:0]       win_row,
  output logic [4:0]       win_col,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
  localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);

  state_t           state;
  logic [4:0]       row;
  logic [4:0]       col;
  logic             accept;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  // Only the two older window columns are stored: the oldest one drops out on
  // the shift and the newest one is taken straight from the line buffers.
  logic [PIX_W-1:0] ca_t, ca_m, ca_b;
  logic [PIX_W-1:0] cb_t, cb_m, cb_b;
  logic [PIX_W-1:0] nr_t, nr_m, nr_b;

  always_comb begin
    pix_ready = ((state == FILL) || (state == STREAM)) && (!valid_out_buf || win_ready);
    accept    = pix_valid && pix_ready;
    busy      = (state != IDLE);
    nr_t      = lb1[col];
    nr_m      = lb0[col];
    nr_b      = pix_in;
  end

  // Line buffers and window columns carry no reset; their contents are only
  // observed after being rewritten by accepted pixels of the current frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_in;
      ca_t     <= cb_t;
      ca_m     <= cb_m;
      ca_b     <= cb_b;
      cb_t     <= nr_t;
      cb_m     <= nr_m;
      cb_b     <= nr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      valid_out_buf <= 1'b0;
      pixel_0       <= '0;
      pixel_1       <= '0;
      pixel_2       <= '0;
      pixel_3       <= '0;
      pixel_4       <= '0;
      pixel_5       <= '0;
      pixel_6       <= '0;
      pixel_7       <= '0;
      pixel_8       <= '0;
      win_row       <= '0;
      win_col       <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A consumed window retires unless a new one is loaded below this cycle.
      if (valid_out_buf && win_ready) begin
        valid_out_buf <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            row   <= '0;
            col   <= '0;
          end
        end

        FILL, STREAM: begin
          if (accept) begin
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end

            if ((state == STREAM) && (col >= 5'd2)) begin
              pixel_0       <= ca_t;
              pixel_1       <= cb_t;
              pixel_2       <= nr_t;
              pixel_3       <= ca_m;
              pixel_4       <= cb_m;
              pixel_5       <= nr_m;
              pixel_6       <= ca_b;
              pixel_7       <= cb_b;
              pixel_8       <= nr_b;
              win_row       <= row - 5'd2;
              win_col       <= col - 5'd2;
              valid_out_buf <= 1'b1;
            end

            if ((state == FILL) && (row == 5'd1) && (col == LAST_COL)) begin
              state <= STREAM;
            end
            if ((state == STREAM) && (row == LAST_ROW) && (col == LAST_COL)) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (!valid_out_buf || win_ready) begin
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_window_ctrl.sv
// Scoreboard bench for conv1_window_ctrl: driver pushes expected windows,
// a negedge monitor pops and compares each consumed window.
module tb_conv1_window_ctrl;

  localparam int W = 28;
  localparam int H = 28;

  typedef logic [81:0] win_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8;
  logic       valid_out_buf;
  logic       win_ready = 1'b1;
  logic [4:0] win_row, win_col;
  logic       busy;
  logic       frame_done;

  conv1_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pixel_0(pixel_0), .pixel_1(pixel_1), .pixel_2(pixel_2), .pixel_3(pixel_3),
    .pixel_4(pixel_4), .pixel_5(pixel_5), .pixel_6(pixel_6), .pixel_7(pixel_7),
    .pixel_8(pixel_8), .valid_out_buf(valid_out_buf), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   win_cnt = 0;
  int   wr_pct = 100;
  logic [9:0] last_rc = '0;
  win_t exp_q[$];

  win_t act;
  assign act = {pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7,
                pixel_8, win_row, win_col};

  localparam win_t FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58, 5'd0, 5'd0};
  localparam win_t ROW1_WIN  = {8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58, 8'd84, 8'd85, 8'd86, 5'd1, 5'd0};

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'((r * W + c) % 256);
  endfunction

  function automatic win_t exp_win(input int r, input int c);
    return {pv(r-2, c-2), pv(r-2, c-1), pv(r-2, c),
            pv(r-1, c-2), pv(r-1, c-1), pv(r-1, c),
            pv(r,   c-2), pv(r,   c-1), pv(r,   c),
            5'(r - 2), 5'(c - 2)};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    win_ready = (int'($urandom_range(99)) < wr_pct);
  end

  win_t held;
  bit   hold = 1'b0;
  win_t e;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        n_vec++;
        if (!valid_out_buf || act !== held) begin
          n_err++;
          $display("FAIL hold_stable: got valid=%0b win=%h expected valid=1 win=%h",
                   valid_out_buf, act, held);
        end
      end
      hold = 1'b0;
      if (valid_out_buf) begin
        if (!win_ready) begin
          held = act;
          hold = 1'b1;
        end else begin
          n_vec++;
          win_cnt++;
          last_rc = act[9:0];
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_window: got %h expected none", act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              n_err++;
              $display("FAIL window: got %h expected %h", act, e);
            end
          end
          if (act[9:0] == 10'd0) begin
            n_vec++;
            if (act !== FIRST_WIN) begin
              n_err++;
              $display("FAIL first_window: got %h expected %h", act, FIRST_WIN);
            end
          end
          if (act[9:0] == {5'd1, 5'd0}) begin
            n_vec++;
            if (act !== ROW1_WIN) begin
              n_err++;
              $display("FAIL row1_window: got %h expected %h", act, ROW1_WIN);
            end
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL done_early: got %0d pending windows expected 0", exp_q.size());
        end
      end
    end
  end

  task automatic send_pixel(input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    pix_in = v;
    pix_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (pix_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    if (!ok) begin
      $display("FAIL pixel_accept_timeout: got no accept expected accept of %h", v);
      $fatal(1, "stalled");
    end
  endtask

  task automatic run_frame(input int vpct, input int rpct, input bit poke_start, input bit b2b);
    int base_done;
    int base_win;
    int cnt;
    wr_pct = rpct;
    base_done = done_cnt;
    base_win = win_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) >= vpct) begin
          pix_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        if (r >= 2 && c >= 2) exp_q.push_back(exp_win(r, c));
        send_pixel(pv(r, c));
        if (poke_start && r == 10 && c == 5) begin
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
    end
    pix_in = 8'hAA;
    pix_valid = 1'b1;
    cnt = 0;
    while (done_cnt == base_done && cnt < 300) begin
      @(negedge clk);
      chk("no_accept_after_last", pix_ready, 0);
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_done_timeout: got no pulse expected pulse");
    end
    if (!b2b) begin
      repeat (3) begin
        @(negedge clk);
        chk("idle_ready_busy", {pix_ready, busy}, 0);
        @(posedge clk);
        #1;
      end
      chk("frame_done_once", done_cnt - base_done, 1);
    end
    pix_valid = 1'b0;
    chk("window_count", win_cnt - base_win, 676);
    chk("last_window_rc", last_rc, {5'd25, 5'd25});
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("reset_state", {pix_ready, valid_out_buf, busy, frame_done, act}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // mid-frame reset
    wr_pct = 100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 70; k++) begin
      if (k / W >= 2 && k % W >= 2) exp_q.push_back(exp_win(k / W, k % W));
      send_pixel(pv(k / W, k % W));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_mid_frame", {pix_ready, valid_out_buf, busy, frame_done, act}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", {pix_ready, valid_out_buf, busy, frame_done, act}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;

    run_frame(100, 100, 1'b0, 1'b0);
    run_frame(100, 50, 1'b0, 1'b0);
    run_frame(30, 100, 1'b0, 1'b0);
    run_frame(100, 100, 1'b1, 1'b1);
    run_frame(100, 100, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
